// File: rtl/seg7_pkg.sv
// Shared constants and types for the scrolling seven-segment driver:
// the fixed hex message, the active-low glyph table and the FSM state type.
package seg7_pkg;

    localparam logic [63:0] MESSAGE = 64'h0123_4567_89AB_CDEF;

    // Active-low cathodes, bit 6 = a through bit 0 = g.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {BLANK, ON} state_t;

    // Code index 0 is the most significant nibble of the message.
    function automatic logic [3:0] message_code(input logic [3:0] idx);
        return MESSAGE[6'd63 - {idx, 2'b00} -: 4];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex code to active-low seven-segment glyph.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH[code];
    end

endmodule

// File: rtl/seg7_scroll_driver.sv
// Time-multiplexed 4-digit common-anode driver showing a scrolling window
// of the fixed hex message; each advance cycle moves the window one step left.
module seg7_scroll_driver
    import seg7_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 12,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [3:0] an,
    output logic [6:0] a2g
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    ptr;
    logic [3:0]    base;
    logic [1:0]    d;
    logic [3:0]    idx;
    logic [3:0]    code;
    logic [6:0]    glyph;

    // Digit 3 loads from the live pointer, the same value latched into base,
    // so the whole frame shares one window.
    always_comb begin
        idx  = ((d == 2'd3) ? ptr : base) + {2'b00, 2'd3 - d};
        code = message_code(idx);
    end

    seg7_decoder u_decoder (
        .code  (code),
        .glyph (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK;
            cnt   <= '0;
            ptr   <= '0;
            base  <= '0;
            d     <= 2'd3;
            an    <= 4'b1111;
            a2g   <= 7'b1111111;
        end else begin
            if (advance) begin
                ptr <= ptr + 4'd1;
            end
            case (state)
                BLANK: begin
                    an <= 4'b1111;
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= ON;
                        an    <= ~(4'b0001 << d);
                        a2g   <= glyph;
                        if (d == 2'd3) begin
                            base <= ptr;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                        an    <= 4'b1111;
                        d     <= d - 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
